mips_multicycle_ctrl: RTL and testbench

//  Multicycle main control FSM for the MIPS core: sequences one shared memory, ALU, PC and register file

---
 rtl/mips_multicycle_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multicycle main control FSM for the MIPS core.
// It sequences the shared memory, ALU, PC and register file through the
// fetch / decode / execute / memory / writeback steps.
// Optional feature macro: MIPS_CTRL_ADDI_EN adds the ADDIEX and ADDIWB
// states. When the macro is undefined, addi decodes as an illegal opcode.
module mips_multicycle_ctrl #(
    parameter logic [5:0] OP_RTYPE = 6'h00,
    parameter logic [5:0] OP_LW    = 6'h23,
    parameter logic [5:0] OP_SW    = 6'h2B,
    parameter logic [5:0] OP_BEQ   = 6'h04,
    parameter logic [5:0] OP_J     = 6'h02,
    parameter logic [5:0] OP_ADDI  = 6'h08
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_en,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_ctrl,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEX   = 4'd6,
        S_RTWB   = 4'd7,
        S_BEQEX  = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JEX    = 4'd11
    } state_t;

    state_t state_q, state_d;
    logic   funct_ok;

    assign state = state_q;

    // Only the five supported R-type functions are legal.
    always_comb begin
        funct_ok = 1'b0;
        case (funct)
            6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: funct_ok = 1'b1;
            default:                           funct_ok = 1'b0;
        endcase
    end

    // State register: the asynchronous reset forces FETCH immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Next-state logic and datapath controls, derived from the current state.
    always_comb begin
        state_d    = state_q;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_en      = 1'b0;
        pc_src     = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_ctrl   = 3'b010;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_en    = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                state_d   = S_FETCH;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE: begin
                        if (funct_ok) begin
                            state_d = S_RTEX;
                        end else begin
                            illegal_op = 1'b1;
                            instr_done = 1'b1;
                        end
                    end
                    OP_BEQ:  state_d = S_BEQEX;
                    OP_J:    state_d = S_JEX;
`ifdef MIPS_CTRL_ADDI_EN
                    OP_ADDI: state_d = S_ADDIEX;
`else
                    OP_ADDI: begin
                        illegal_op = 1'b1;
                        instr_done = 1'b1;
                    end
`endif
                    default: begin
                        illegal_op = 1'b1;
                        instr_done = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                if (opcode == OP_SW) state_d = S_MEMWR;
                else if (opcode == OP_LW) state_d = S_MEMRD;
                else state_d = S_FETCH;
            end
            S_MEMRD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_RTEX: begin
                alu_src_a = 1'b1;
                case (funct)
                    6'h22:   alu_ctrl = 3'b110;
                    6'h24:   alu_ctrl = 3'b000;
                    6'h25:   alu_ctrl = 3'b001;
                    6'h2A:   alu_ctrl = 3'b111;
                    default: alu_ctrl = 3'b010;
                endcase
                state_d = S_RTWB;
            end
            S_RTWB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BEQEX: begin
                alu_src_a  = 1'b1;
                alu_ctrl   = 3'b110;
                pc_src     = 2'b01;
                pc_en      = zero;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
`ifdef MIPS_CTRL_ADDI_EN
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
`endif
            S_JEX: begin
                pc_src     = 2'b10;
                pc_en      = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
        // While reset is held, all controls are quiet even though the state reads FETCH.
        if (!reset) begin
            iord       = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            pc_en      = 1'b0;
            pc_src     = 2'b00;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            alu_ctrl   = 3'b010;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            reg_write  = 1'b0;
            instr_done = 1'b0;
            illegal_op = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: vector-table bench for mips_multicycle_ctrl.
// Each table row is {reset, opcode, funct, zero, mem_ready} followed by the
// expected state and control word. A row is applied after a falling clock
// edge and checked 1 time unit later.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, funct;
    logic       zero, mem_ready;
    logic       iord, mem_read, mem_write, ir_write, pc_en;
    logic [1:0] pc_src, alu_src_b;
    logic       alu_src_a;
    logic [2:0] alu_ctrl;
    logic       reg_dst, mem_to_reg, reg_write, instr_done, illegal_op;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .pc_en(pc_en), .pc_src(pc_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .instr_done(instr_done),
        .illegal_op(illegal_op), .state(state)
    );

    // Control word layout:
    // {iord,mem_read,mem_write,ir_write,pc_en}, pc_src, alu_src_a, alu_src_b, alu_ctrl,
    // {reg_dst,mem_to_reg,reg_write,instr_done,illegal_op}
    logic [17:0] act;
    assign act = {iord, mem_read, mem_write, ir_write, pc_en, pc_src, alu_src_a, alu_src_b,
                  alu_ctrl, reg_dst, mem_to_reg, reg_write, instr_done, illegal_op};

    localparam logic [17:0] C_RST  = {5'b00000, 2'b00, 1'b0, 2'b00, 3'b010, 5'b00000};
    localparam logic [17:0] C_FWT  = {5'b01000, 2'b00, 1'b0, 2'b01, 3'b010, 5'b00000};
    localparam logic [17:0] C_FGO  = {5'b01011, 2'b00, 1'b0, 2'b01, 3'b010, 5'b00000};
    localparam logic [17:0] C_DEC  = {5'b00000, 2'b00, 1'b0, 2'b11, 3'b010, 5'b00000};
    localparam logic [17:0] C_DILL = {5'b00000, 2'b00, 1'b0, 2'b11, 3'b010, 5'b00011};
    localparam logic [17:0] C_MADR = {5'b00000, 2'b00, 1'b1, 2'b10, 3'b010, 5'b00000};
    localparam logic [17:0] C_MRD  = {5'b11000, 2'b00, 1'b0, 2'b00, 3'b010, 5'b00000};
    localparam logic [17:0] C_MWB  = {5'b00000, 2'b00, 1'b0, 2'b00, 3'b010, 5'b01110};
    localparam logic [17:0] C_MWRW = {5'b10100, 2'b00, 1'b0, 2'b00, 3'b010, 5'b00000};
    localparam logic [17:0] C_MWRG = {5'b10100, 2'b00, 1'b0, 2'b00, 3'b010, 5'b00010};
    localparam logic [17:0] C_RSUB = {5'b00000, 2'b00, 1'b1, 2'b00, 3'b110, 5'b00000};
    localparam logic [17:0] C_RAND = {5'b00000, 2'b00, 1'b1, 2'b00, 3'b000, 5'b00000};
    localparam logic [17:0] C_RSLT = {5'b00000, 2'b00, 1'b1, 2'b00, 3'b111, 5'b00000};
    localparam logic [17:0] C_RTWB = {5'b00000, 2'b00, 1'b0, 2'b00, 3'b010, 5'b10110};
    localparam logic [17:0] C_BEQT = {5'b00001, 2'b01, 1'b1, 2'b00, 3'b110, 5'b00010};
    localparam logic [17:0] C_BEQN = {5'b00000, 2'b01, 1'b1, 2'b00, 3'b110, 5'b00010};
    localparam logic [17:0] C_JEX  = {5'b00001, 2'b10, 1'b0, 2'b00, 3'b010, 5'b00010};
    localparam logic [17:0] C_AWB  = {5'b00000, 2'b00, 1'b0, 2'b00, 3'b010, 5'b00110};

    typedef struct {
        logic        rst_n;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        rdy;
        logic [3:0]  st;
        logic [17:0] ctl;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic rdy, input logic [3:0] st,
                       input logic [17:0] ctl);
        vec_t v;
        v.rst_n = r; v.op = op; v.fn = fn; v.z = z; v.rdy = rdy; v.st = st; v.ctl = ctl;
        vq.push_back(v);
    endtask

    // Runs one instruction from FETCH with mem_ready=1 and returns its observed behaviour.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             output int cyc, output int dones, output int rws,
                             output int viol, output bit ok);
        logic [3:0] wr;
        cyc = 0; dones = 0; rws = 0; viol = 0; ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            opcode = op; funct = fn; zero = z; mem_ready = 1'b1;
            #1;
            cyc++;
            if (instr_done) dones++;
            if (reg_write) rws++;
            wr = {reg_write, mem_write, pc_en, ir_write};
            if ($countones(wr) > 1 && wr != 4'b0011) viol++;
            if (instr_done) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clk);
        mem_ready = 1'b0;
    endtask

    task automatic chk_instr(input string nm, input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input int exp_cyc, input int exp_rw);
        int  cyc, dones, rws, viol;
        bit  ok;
        run_instr(op, fn, z, cyc, dones, rws, viol, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s timeout: instr_done not seen within 20 cycles", nm);
        end
        checks++;
        if (cyc != exp_cyc) begin
            errors++;
            $display("FAIL %s latency got %0d want %0d", nm, cyc, exp_cyc);
        end
        checks++;
        if (rws != exp_rw || dones != 1) begin
            errors++;
            $display("FAIL %s reg_write cycles got %0d want %0d, instr_done got %0d want 1",
                     nm, rws, exp_rw, dones);
        end
        checks++;
        if (viol != 0) begin
            errors++;
            $display("FAIL %s enable overlap got %0d want 0", nm, viol);
        end
        #1;
        checks++;
        if (state != 4'd0) begin
            errors++;
            $display("FAIL %s return state got %0d want 0", nm, state);
        end
    endtask

    initial begin
        reset = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;

        // reset
        add(0, 6'h00, 6'h00, 0, 0, 4'd0, C_RST);
        add(0, 6'h00, 6'h00, 0, 1, 4'd0, C_RST);
        // fetch stall, then lw with mem_ready=1
        add(1, 6'h23, 6'h00, 0, 0, 4'd0, C_FWT);
        add(1, 6'h23, 6'h00, 0, 0, 4'd0, C_FWT);
        add(1, 6'h23, 6'h00, 0, 1, 4'd0, C_FGO);
        add(1, 6'h23, 6'h00, 0, 1, 4'd1, C_DEC);
        add(1, 6'h23, 6'h00, 0, 1, 4'd2, C_MADR);
        add(1, 6'h23, 6'h00, 0, 1, 4'd3, C_MRD);
        add(1, 6'h23, 6'h00, 0, 1, 4'd4, C_MWB);
        // sw with memory stalled three cycles
        add(1, 6'h2B, 6'h00, 0, 1, 4'd0, C_FGO);
        add(1, 6'h2B, 6'h00, 0, 1, 4'd1, C_DEC);
        add(1, 6'h2B, 6'h00, 0, 1, 4'd2, C_MADR);
        add(1, 6'h2B, 6'h00, 0, 0, 4'd5, C_MWRW);
        add(1, 6'h2B, 6'h00, 0, 0, 4'd5, C_MWRW);
        add(1, 6'h2B, 6'h00, 0, 0, 4'd5, C_MWRW);
        add(1, 6'h2B, 6'h00, 0, 1, 4'd5, C_MWRG);
        // beq taken, then not taken
        add(1, 6'h04, 6'h00, 1, 1, 4'd0, C_FGO);
        add(1, 6'h04, 6'h00, 1, 1, 4'd1, C_DEC);
        add(1, 6'h04, 6'h00, 1, 1, 4'd8, C_BEQT);
        add(1, 6'h04, 6'h00, 0, 1, 4'd0, C_FGO);
        add(1, 6'h04, 6'h00, 0, 1, 4'd1, C_DEC);
        add(1, 6'h04, 6'h00, 0, 1, 4'd8, C_BEQN);
        // R-type sub, and, slt
        add(1, 6'h00, 6'h22, 0, 1, 4'd0, C_FGO);
        add(1, 6'h00, 6'h22, 0, 1, 4'd1, C_DEC);
        add(1, 6'h00, 6'h22, 0, 1, 4'd6, C_RSUB);
        add(1, 6'h00, 6'h22, 0, 1, 4'd7, C_RTWB);
        add(1, 6'h00, 6'h24, 0, 1, 4'd0, C_FGO);
        add(1, 6'h00, 6'h24, 0, 1, 4'd1, C_DEC);
        add(1, 6'h00, 6'h24, 0, 1, 4'd6, C_RAND);
        add(1, 6'h00, 6'h24, 0, 1, 4'd7, C_RTWB);
        add(1, 6'h00, 6'h2A, 0, 1, 4'd0, C_FGO);
        add(1, 6'h00, 6'h2A, 0, 1, 4'd1, C_DEC);
        add(1, 6'h00, 6'h2A, 0, 1, 4'd6, C_RSLT);
        add(1, 6'h00, 6'h2A, 0, 1, 4'd7, C_RTWB);
        // illegal funct, then illegal opcode
        add(1, 6'h00, 6'h3F, 0, 1, 4'd0, C_FGO);
        add(1, 6'h00, 6'h3F, 0, 1, 4'd1, C_DILL);
        add(1, 6'h3F, 6'h00, 0, 1, 4'd0, C_FGO);
        add(1, 6'h3F, 6'h00, 0, 1, 4'd1, C_DILL);
        // jump
        add(1, 6'h02, 6'h00, 0, 1, 4'd0, C_FGO);
        add(1, 6'h02, 6'h00, 0, 1, 4'd1, C_DEC);
        add(1, 6'h02, 6'h00, 0, 1, 4'd11, C_JEX);
        // addi
        add(1, 6'h08, 6'h00, 0, 1, 4'd0, C_FGO);
`ifdef MIPS_CTRL_ADDI_EN
        add(1, 6'h08, 6'h00, 0, 1, 4'd1, C_DEC);
        add(1, 6'h08, 6'h00, 0, 1, 4'd9, C_MADR);
        add(1, 6'h08, 6'h00, 0, 1, 4'd10, C_AWB);
`else
        add(1, 6'h08, 6'h00, 0, 1, 4'd1, C_DILL);
`endif
        // reset asserted for three cycles in the middle of MEMRD
        add(1, 6'h23, 6'h00, 0, 1, 4'd0, C_FGO);
        add(1, 6'h23, 6'h00, 0, 1, 4'd1, C_DEC);
        add(1, 6'h23, 6'h00, 0, 1, 4'd2, C_MADR);
        add(1, 6'h23, 6'h00, 0, 0, 4'd3, C_MRD);
        add(0, 6'h23, 6'h00, 0, 1, 4'd0, C_RST);
        add(0, 6'h23, 6'h00, 0, 1, 4'd0, C_RST);
        add(0, 6'h23, 6'h00, 0, 1, 4'd0, C_RST);
        add(1, 6'h23, 6'h00, 0, 0, 4'd0, C_FWT);
        add(1, 6'h23, 6'h00, 0, 0, 4'd0, C_FWT);

        foreach (vq[i]) begin
            @(negedge clk);
            reset = vq[i].rst_n; opcode = vq[i].op; funct = vq[i].fn;
            zero = vq[i].z; mem_ready = vq[i].rdy;
            #1;
            checks++;
            if (state !== vq[i].st) begin
                errors++;
                $display("FAIL vec%0d state got %0d want %0d", i, state, vq[i].st);
            end
            checks++;
            if (act !== vq[i].ctl) begin
                errors++;
                $display("FAIL vec%0d controls got %018b want %018b", i, act, vq[i].ctl);
            end
        end

        // Whole-instruction latency, write counts and enable exclusivity.
        chk_instr("lw",   6'h23, 6'h00, 1'b0, 5, 1);
        chk_instr("sw",   6'h2B, 6'h00, 1'b0, 4, 0);
        chk_instr("add",  6'h00, 6'h20, 1'b0, 4, 1);
        chk_instr("or",   6'h00, 6'h25, 1'b0, 4, 1);
        chk_instr("beq",  6'h04, 6'h00, 1'b1, 3, 0);
        chk_instr("j",    6'h02, 6'h00, 1'b0, 3, 0);
        chk_instr("ill",  6'h00, 6'h3F, 1'b0, 2, 0);
`ifdef MIPS_CTRL_ADDI_EN
        chk_instr("addi", 6'h08, 6'h00, 1'b0, 4, 1);
`else
        chk_instr("addi", 6'h08, 6'h00, 1'b0, 2, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
